if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage. It drives the PC onto a split request/response instruction-memory interface (addr_ok / data_ok handshakes) and tracks multiple outstanding requests. Returned instructions are buffered in a DEPTH-entry queue that feeds decode through a valid/ready handshake. Redirects (branch, exception, eret) are unified into one redirect port; in-flight responses from the old stream are discarded.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value after reset
DEPTH, 4, queue entries and maximum outstanding requests (power of 2, ≥2)
PTR_W, $clog2(DEPTH), queue pointer width (derived, do not override)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect the fetch stream this cycle (branch/exception/eret already arbitrated upstream)
redirect_pc  in  32  new fetch PC
inst_req  out  1  request valid
inst_addr  out  32  request address (current PC)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response valid (in order)
inst_rdata  in  32  response instruction
dec_valid  out  1  queue head valid
dec_ready  in  1  decode consumes head
dec_inst  out  32  head instruction (0 if exception entry)
dec_pc  out  32  head PC
dec_exc  out  1  head carries fetch address error
dec_exccode  out  5  5'd4 (AdEL) when dec_exc, else 0

Behaviour:
- Reset (async, resetn=0): pc=RESET_PC; queue empty; outstanding=0; discard=0; state RUN; inst_req=0; dec_valid=0; dec_inst/dec_pc/dec_exc/dec_exccode=0.
- Credit: inst_req = (state==RUN) && !redirect_valid && pc[1:0]==0 && (count+outstanding < DEPTH). inst_addr = pc.
- Request handshake: inst_req && inst_addr_ok → pc += 4; outstanding += 1; the PC is pushed to an in-order PC-tag FIFO (DEPTH deep).
- Response: inst_data_ok with discard>0 → discard -= 1, data and tag dropped. Otherwise enqueue {rdata, tag PC, exc=0}. outstanding -= 1 in both cases. A request and a response in the same cycle leave outstanding unchanged.
- Misaligned PC (pc[1:0]!=0) in RUN with a free slot: enqueue {inst=0, pc, exc=1, exccode=4} without a memory request; state→HALT. HALT issues nothing until a redirect arrives.
- Dequeue: dec_valid && dec_ready pops the head. Latency from data_ok to dec_valid is 1 cycle (queue registered).
- Redirect (highest priority):
  - pc←redirect_pc; state←RUN; queue cleared (count=0); any pop in the same cycle is ignored.
  - discard ← outstanding − (data_ok that cycle ? 1 : 0); outstanding keeps counting.
  - No request is issued in the redirect cycle.
- Width rules: count and outstanding are PTR_W+1 bits; pointers wrap modulo DEPTH; pc+4 wraps at 2^32.
- Full: count+outstanding==DEPTH blocks requests, so data_ok can never hit a full queue (assertion).
- Reset mid-transaction: all state cleared immediately. Responses after reset are outside the contract; memory is reset together with this block.

Optional Feature:
IF_BYPASS_EN
- Defined: when the queue is empty and an accepted (non-discarded) response arrives, dec_valid/dec_inst/dec_pc are driven combinationally from inst_rdata and the tag. If dec_ready is high the entry is not written; otherwise it is enqueued normally. Zero-cycle latency.
- Undefined: every response goes through the queue; minimum latency 1 cycle.

Decomposition:
- Shared package if_pkg: RESET_PC default, EXC_ADEL=5'd4, typedef fetch_entry_t {inst[31:0], pc[31:0], exc}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, flush, count) is instantiated twice: entry queue and PC-tag FIFO.

Test Plan:
- Reset, addr_ok=1, data_ok one cycle later with rdata=PC → dec sequence BFC00000, BFC00004, BFC00008, each with inst=pc, dec_exc=0.
- dec_ready=0, DEPTH=4 → after 4 accepts inst_req drops and stays 0 until a pop; no response lost.
- Two requests outstanding, redirect to 0x80001000 → both responses dropped; next dec_pc=0x80001000; queue empty in the redirect cycle.
- Redirect to 0x80000002 → no request issued; one entry dec_exc=1, dec_exccode=4, dec_inst=0, dec_pc=0x80000002; halts until a redirect to 0xBFC00380 resumes fetch.
- Redirect coincident with data_ok and pop → data dropped, pop ignored, discard=outstanding−1.
- IF_BYPASS_EN defined, empty queue, dec_ready=1 → dec_valid in the same cycle as data_ok; undefined → one cycle later.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch queue
//
// Purpose: reset PC default, fetch exception code, queue entry layout and
//          fetch state encoding used by if_fetch_queue and its queues.
// Ports:   none (package).
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and occupancy count
//
// Purpose: DEPTH-entry first-in first-out buffer (DEPTH a power of two);
//          head_data always shows the oldest entry.
// Ports:   clk, resetn (async active-low), flush (empties the FIFO, wins
//          over push/pop), push/push_data, pop, head_data, count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= push_data;
    end

    // Callers must never overflow or underflow the FIFO.
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            assert (!(push && !pop && count_q == (PTR_W+1)'(DEPTH)));
            assert (!(pop && count_q == '0));
        end
    end

    assign head_data = mem_q[rptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with outstanding-request tracking and decode queue
//
// Purpose: issues PC requests on a split addr_ok/data_ok instruction bus,
//          buffers in-order responses in a DEPTH-entry queue for decode and
//          discards responses that belong to a stream abandoned by redirect.
//          A misaligned PC produces one AdEL entry and halts until redirected.
// Option:  IF_BYPASS_EN - when defined, an accepted response arriving at an
//          empty queue is presented to decode in the same cycle.
// Ports:   clk, resetn (async active-low); redirect_valid/redirect_pc;
//          inst_req/inst_addr/inst_addr_ok (request), inst_data_ok/inst_rdata
//          (response); dec_valid/dec_ready/dec_inst/dec_pc/dec_exc/dec_exccode.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_exc,
    output logic [4:0]  dec_exccode
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]    pc_q, pc_d;
    fetch_state_e   state_q, state_d;
    logic [PTR_W:0] discard_q, discard_d;

    logic [PTR_W:0]   q_count, tag_count;
    logic [PTR_W+1:0] in_flight;
    fetch_entry_t     q_head, q_push_data;
    logic [31:0]      tag_head;
    logic             q_push, q_pop;
    logic             free_slot, req_fire, exc_fire, rsp_keep, byp;

    always_comb begin
        // Queued entries plus outstanding requests never exceed DEPTH, so a
        // response always finds room in the queue.
        in_flight = {1'b0, q_count} + {1'b0, tag_count};
        free_slot = in_flight < (PTR_W+2)'(DEPTH);

        inst_addr = pc_q;
        inst_req  = resetn && (state_q == ST_RUN) && !redirect_valid
                    && (pc_q[1:0] == 2'b00) && free_slot;
        req_fire  = inst_req && inst_addr_ok;
        exc_fire  = (state_q == ST_RUN) && !redirect_valid
                    && (pc_q[1:0] != 2'b00) && free_slot;

        // A response is kept only if it was issued after the last redirect.
        rsp_keep  = inst_data_ok && (discard_q == '0) && !redirect_valid;
`ifdef IF_BYPASS_EN
        byp       = rsp_keep && (q_count == '0);
`else
        byp       = 1'b0;
`endif

        dec_valid = 1'b0;
        dec_inst  = '0;
        dec_pc    = '0;
        dec_exc   = 1'b0;
        if (q_count != '0) begin
            dec_valid = 1'b1;
            dec_inst  = q_head.inst;
            dec_pc    = q_head.pc;
            dec_exc   = q_head.exc;
        end else if (byp) begin
            dec_valid = 1'b1;
            dec_inst  = inst_rdata;
            dec_pc    = tag_head;
        end
        dec_exccode = dec_exc ? EXC_ADEL : 5'd0;

        q_pop = (q_count != '0) && dec_ready && !redirect_valid;

        // A kept response and a misaligned-PC entry never coincide: the PC can
        // only become misaligned through a redirect, which marks every
        // outstanding response for discard.
        q_push      = 1'b0;
        q_push_data = '{inst: inst_rdata, pc: tag_head, exc: 1'b0};
        if (rsp_keep && !(byp && dec_ready)) begin
            q_push = 1'b1;
        end else if (exc_fire) begin
            q_push      = 1'b1;
            q_push_data = '{inst: 32'd0, pc: pc_q, exc: 1'b1};
        end

        pc_d      = pc_q;
        state_d   = state_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            state_d   = ST_RUN;
            // The response returning this cycle is dropped directly, the rest
            // of the outstanding requests are dropped as they come back.
            discard_d = tag_count - {{PTR_W{1'b0}}, inst_data_ok};
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (exc_fire) state_d = ST_HALT;
            if (inst_data_ok && discard_q != '0)
                discard_d = discard_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            state_q   <= ST_RUN;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Decoded-instruction queue; a redirect throws away the old stream.
    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    // PC of every outstanding request in issue order; its occupancy is the
    // outstanding-request count, which keeps counting across redirects.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (inst_data_ok),
        .head_data (tag_head),
        .count     (tag_count)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue with randomized traffic and a queue-based model
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_exc;
    logic [4:0]  dec_exccode;

    always #5 clk = ~clk;

    if_fetch_queue #(.RESET_PC(32'hBFC0_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_exc        (dec_exc),
        .dec_exccode    (dec_exccode)
    );

    typedef struct { logic [31:0] inst; logic [31:0] pc; logic exc; } ent_t;
    typedef struct { logic [31:0] pc; logic stale; } tag_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic exc; logic [4:0] code; int cyc; } pop_t;

    ent_t mq[$];      // entries waiting for decode
    tag_t mt[$];      // accepted, unanswered requests (memory side)
    pop_t plog[$];    // what decode actually consumed
    logic [31:0] m_pc;
    bit          m_run;

    int n_chk = 0, n_pass = 0;
    int cyc, n_acc;
    bit last_dec_valid, last_req;
    int k_addr, k_data, k_ready, k_redir;
    logic [31:0] k_xor;
    bit          redir_once;
    logic [31:0] redir_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        mt.delete();
        m_pc  = 32'hBFC0_0000;
        m_run = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst_req"},    32'(inst_req),    32'd0);
        chk({tag, "_dec_valid"},   32'(dec_valid),   32'd0);
        chk({tag, "_dec_inst"},    dec_inst,         32'd0);
        chk({tag, "_dec_pc"},      dec_pc,           32'd0);
        chk({tag, "_dec_exc"},     32'(dec_exc),     32'd0);
        chk({tag, "_dec_exccode"}, 32'(dec_exccode), 32'd0);
    endtask

    task automatic drive();
        logic [1:0] lo;
        if (redir_once) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_once     = 1'b0;
        end else if ($urandom_range(99) < k_redir) begin
            lo = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h8000_0000 | (32'($urandom_range(1023)) << 2) | 32'(lo);
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        inst_addr_ok = ($urandom_range(99) < k_addr);
        inst_data_ok = (mt.size() > 0) && ($urandom_range(99) < k_data);
        inst_rdata   = inst_data_ok ? (mt[0].pc ^ k_xor) : $urandom;
        dec_ready    = ($urandom_range(99) < k_ready);
    endtask

    task automatic check_update();
        bit   redir, e_req, e_exc, acc, byp, e_val, consumed;
        int   inflight;
        ent_t h;
        tag_t t;
        redir    = redirect_valid;
        inflight = mq.size() + mt.size();
        e_req    = m_run && !redir && (m_pc[1:0] == 2'b00) && (inflight < DEPTH);
        e_exc    = m_run && !redir && (m_pc[1:0] != 2'b00) && (inflight < DEPTH);
        acc      = 1'b0;
        if (inst_data_ok) acc = !redir && !mt[0].stale;
        byp = 1'b0;
`ifdef IF_BYPASS_EN
        byp = acc && (mq.size() == 0);
`endif
        e_val = 1'b1;
        h     = '{inst: 32'd0, pc: 32'd0, exc: 1'b0};
        if (mq.size() > 0) h = mq[0];
        else if (byp)      h = '{inst: inst_rdata, pc: mt[0].pc, exc: 1'b0};
        else               e_val = 1'b0;

        chk("inst_req", 32'(inst_req), 32'(e_req));
        if (e_req) chk("inst_addr", inst_addr, m_pc);
        chk("dec_valid", 32'(dec_valid), 32'(e_val));
        if (e_val) begin
            chk("dec_inst",    dec_inst,          h.inst);
            chk("dec_pc",      dec_pc,            h.pc);
            chk("dec_exc",     32'(dec_exc),      32'(h.exc));
            chk("dec_exccode", 32'(dec_exccode),  h.exc ? 32'd4 : 32'd0);
        end

        if (dec_valid && dec_ready && !redir)
            plog.push_back('{inst: dec_inst, pc: dec_pc, exc: dec_exc, code: dec_exccode, cyc: cyc});
        last_dec_valid = dec_valid;
        last_req       = inst_req;
        if (inst_req && inst_addr_ok) n_acc++;

        if (redir) begin
            if (inst_data_ok) void'(mt.pop_front());
            foreach (mt[i]) mt[i].stale = 1'b1;
            mq.delete();
            m_pc  = redirect_pc;
            m_run = 1'b1;
        end else begin
            consumed = 1'b0;
            if (e_val && dec_ready) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else consumed = 1'b1;
            end
            if (inst_data_ok) begin
                t = mt.pop_front();
                if (!t.stale && !consumed) mq.push_back('{inst: inst_rdata, pc: t.pc, exc: 1'b0});
            end
            if (e_req && inst_addr_ok) begin
                mt.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (e_exc) begin
                mq.push_back('{inst: 32'd0, pc: m_pc, exc: 1'b1});
                m_run = 1'b0;
            end
        end
        cyc++;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            check_update();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic knobs(input int a, input int d, input int r, input int x);
        k_addr = a; k_data = d; k_ready = r; k_redir = x;
    endtask

    initial begin
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; dec_ready = 1'b0;
        redir_once = 1'b0; redir_tgt = '0; k_xor = '0; cyc = 0; n_acc = 0;
        knobs(0, 0, 0, 0);
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Back-to-back fetch from the reset vector.
        knobs(100, 100, 100, 0);
        plog.delete(); cyc = 0;
        step(8);
        chk("p1_pop_count_ge3", 32'(plog.size() >= 3), 32'd1);
        if (plog.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("p1_pc",   plog[i].pc,       32'hBFC0_0000 + 32'(4 * i));
                chk("p1_inst", plog[i].inst,     32'hBFC0_0000 + 32'(4 * i));
                chk("p1_exc",  32'(plog[i].exc), 32'd0);
            end
`ifdef IF_BYPASS_EN
            chk("p1_first_pop_cycle", 32'(plog[0].cyc), 32'd1);
`else
            chk("p1_first_pop_cycle", 32'(plog[0].cyc), 32'd2);
`endif
        end

        // Decode stalled: exactly DEPTH requests accepted, then credit runs out.
        knobs(0, 100, 100, 0); step(8);
        knobs(100, 100, 0, 0); n_acc = 0;
        step(10);
        chk("full_accepts",   32'(n_acc),          32'd4);
        chk("full_req_low",   32'(last_req),       32'd0);
        chk("full_dec_valid", 32'(last_dec_valid), 32'd1);
        knobs(0, 100, 100, 0); step(8);

        // Two queued, two outstanding; redirect coincides with data_ok and pop.
        knobs(100, 100, 0, 0); step(3);
        knobs(100, 0, 0, 0);   step(1);
        knobs(100, 100, 100, 0);
        redir_once = 1'b1; redir_tgt = 32'h8000_1000;
        plog.delete();
        step(1);
        chk("redir_cycle_req", 32'(last_req), 32'd0);
        step(1);
        chk("redir_q_cleared", 32'(last_dec_valid), 32'd0);
        step(6);
        chk("redir_pop_count_ge1", 32'(plog.size() >= 1), 32'd1);
        if (plog.size() >= 1) begin
            chk("redir_first_pc",   plog[0].pc,   32'h8000_1000);
            chk("redir_first_inst", plog[0].inst, 32'h8000_1000);
        end

        // Misaligned redirect: one AdEL entry, then halt until redirected.
        knobs(0, 100, 100, 0); step(8);
        knobs(100, 100, 100, 0);
        redir_once = 1'b1; redir_tgt = 32'h8000_0002;
        plog.delete(); n_acc = 0;
        step(6);
        chk("adel_no_requests", 32'(n_acc),       32'd0);
        chk("adel_one_entry",   32'(plog.size()), 32'd1);
        if (plog.size() >= 1) begin
            chk("adel_pc",   plog[0].pc,        32'h8000_0002);
            chk("adel_exc",  32'(plog[0].exc),  32'd1);
            chk("adel_code", 32'(plog[0].code), 32'd4);
            chk("adel_inst", plog[0].inst,      32'd0);
        end
        redir_once = 1'b1; redir_tgt = 32'hBFC0_0380;
        step(6);
        chk("resume_pop_count_ge2", 32'(plog.size() >= 2), 32'd1);
        if (plog.size() >= 2) chk("resume_pc", plog[1].pc, 32'hBFC0_0380);

        // PC wrap at 2^32, then randomized traffic with distinct data/PC.
        k_xor = 32'h0F0F_1234;
        redir_once = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        step(10);
        knobs(70, 60, 60, 4);
        step(3000);

        // Asynchronous reset in the middle of traffic.
        #3;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        k_xor = '0;
        knobs(100, 100, 100, 0);
        plog.delete(); cyc = 0;
        step(6);
        chk("after_reset_pop_ge1", 32'(plog.size() >= 1), 32'd1);
        if (plog.size() >= 1) chk("after_reset_pc", plog[0].pc, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
